fpga_sram_loader: RTL



---
 rtl/fpga_sram_loader_pkg.sv | 23 ++
 rtl/fpga_sram_loader_if.sv | 31 +++
 rtl/fpga_sram_loader_ch_mux.sv | 50 +++++
 rtl/fpga_sram_loader.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/fpga_sram_loader_pkg.sv
// Shared types for the FPGA SRAM backdoor loader: mode / host-FSM encodings and sizing helpers.
package fpga_sram_loader_pkg;

  localparam int unsigned FSL_MAX_CH = 8;

  typedef enum logic [1:0] {
    MODE_LOAD   = 2'd0,
    MODE_RUN    = 2'd1,
    MODE_LOCKED = 2'd2
  } fsl_mode_e;

  typedef enum logic [1:0] {
    HS_IDLE,
    HS_PEND,
    HS_RDCAP,
    HS_ACK
  } fsl_host_state_e;

  function automatic int unsigned fsl_ch_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fpga_sram_loader_if.sv
// FPGA-host request/ack port of the SRAM loader (AXI-to-native bridge side).
interface fpga_sram_loader_if #(
  parameter int unsigned NUM_CH = 2,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 15
);
  import fpga_sram_loader_pkg::*;

  localparam int unsigned CH_W = fsl_ch_w(NUM_CH);

  logic                  host_req;
  logic                  host_we;
  logic [DATA_W/8-1:0]   host_be;
  logic [CH_W-1:0]       host_ch;
  logic [ADDR_W-1:0]     host_addr;
  logic [DATA_W-1:0]     host_wdata;
  logic                  host_ack;
  logic                  host_err;
  logic [DATA_W-1:0]     host_rdata;

  modport master (
    output host_req, host_we, host_be, host_ch, host_addr, host_wdata,
    input  host_ack, host_err, host_rdata
  );

  modport slave (
    input  host_req, host_we, host_be, host_ch, host_addr, host_wdata,
    output host_ack, host_err, host_rdata
  );

endinterface

// File: rtl/fpga_sram_loader_ch_mux.sv
// Per-channel ownership decision and SRAM strobe mux between core and latched host request.
module fpga_sram_loader_ch_mux
  import fpga_sram_loader_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 15
) (
  input  fsl_mode_e             mode,
  input  logic                  core_cs,
  input  logic                  core_we,
  input  logic [ADDR_W-1:0]     core_addr,
  input  logic [DATA_W-1:0]     core_wdata,
  input  logic                  host_sel,
  input  logic                  host_we,
  input  logic [DATA_W/8-1:0]   host_be,
  input  logic [ADDR_W-1:0]     host_addr,
  input  logic [DATA_W-1:0]     host_wdata,
  output logic                  host_grant,
  output logic                  sram_cs,
  output logic [DATA_W/8-1:0]   sram_we,
  output logic [ADDR_W-1:0]     sram_addr,
  output logic [DATA_W-1:0]     sram_wdata
);

  localparam int unsigned BE_W = DATA_W / 8;

  logic host_own;

  always_comb begin
    host_own   = (mode == MODE_LOAD) || ((mode == MODE_RUN) && !core_cs);
    host_grant = host_sel && host_own;
    sram_cs    = 1'b0;
    sram_we    = '0;
    sram_addr  = '0;
    sram_wdata = '0;
    // Core strobes are ignored in LOAD; otherwise the core always wins the channel.
    if ((mode != MODE_LOAD) && core_cs) begin
      sram_cs    = 1'b1;
      sram_we    = {BE_W{core_we}};
      sram_addr  = core_addr;
      sram_wdata = core_wdata;
    end else if (host_grant) begin
      sram_cs    = 1'b1;
      sram_we    = host_be & {BE_W{host_we}};
      sram_addr  = host_addr;
      sram_wdata = host_wdata;
    end
  end

endmodule

// File: rtl/fpga_sram_loader.sv
// Multi-channel SRAM backdoor: mode FSM, host request FSM and per-channel muxes.
// Optional per-channel host-write checksum enabled by FPGA_SRAM_LOADER_CKSUM_EN.
module fpga_sram_loader
  import fpga_sram_loader_pkg::*;
#(
  parameter int unsigned NUM_CH = 2,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 15
) (
  input  logic                         clk,
  input  logic                         cptra_rst_b,
  input  logic                         load_go,
  input  logic                         lock,
  output logic [1:0]                   mode,
  output logic                         core_hold,
  fpga_sram_loader_if.slave            hif,
  input  logic [NUM_CH-1:0]            core_cs,
  input  logic [NUM_CH-1:0]            core_we,
  input  logic [NUM_CH*ADDR_W-1:0]     core_addr,
  input  logic [NUM_CH*DATA_W-1:0]     core_wdata,
  output logic [NUM_CH*DATA_W-1:0]     core_rdata,
  output logic [NUM_CH-1:0]            sram_cs,
  output logic [NUM_CH*DATA_W/8-1:0]   sram_we,
  output logic [NUM_CH*ADDR_W-1:0]     sram_addr,
  output logic [NUM_CH*DATA_W-1:0]     sram_wdata,
  input  logic [NUM_CH*DATA_W-1:0]     sram_rdata,
  output logic [NUM_CH*32-1:0]         cksum
);

  localparam int unsigned BE_W = DATA_W / 8;
  localparam int unsigned CH_W = fsl_ch_w(NUM_CH);

  fsl_mode_e         mode_q;
  fsl_host_state_e   hs_q;
  logic              lat_we;
  logic [BE_W-1:0]   lat_be;
  logic [CH_W-1:0]   lat_ch;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;
  logic [NUM_CH-1:0] host_sel;
  logic [NUM_CH-1:0] host_grant;
  logic              ch_ok;
  logic [DATA_W-1:0] sel_rdata;

  assign mode       = mode_q;
  assign core_rdata = sram_rdata;

  always_comb begin
    ch_ok     = 1'b0;
    sel_rdata = '0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      if (lat_ch == CH_W'(c)) begin
        ch_ok     = 1'b1;
        sel_rdata = sram_rdata[c*DATA_W +: DATA_W];
      end
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    assign host_sel[g] = (hs_q == HS_PEND) && (lat_ch == CH_W'(g));

    fpga_sram_loader_ch_mux #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
    ) u_ch_mux (
      .mode       (mode_q),
      .core_cs    (core_cs[g]),
      .core_we    (core_we[g]),
      .core_addr  (core_addr[g*ADDR_W +: ADDR_W]),
      .core_wdata (core_wdata[g*DATA_W +: DATA_W]),
      .host_sel   (host_sel[g]),
      .host_we    (lat_we),
      .host_be    (lat_be),
      .host_addr  (lat_addr),
      .host_wdata (lat_wdata),
      .host_grant (host_grant[g]),
      .sram_cs    (sram_cs[g]),
      .sram_we    (sram_we[g*BE_W +: BE_W]),
      .sram_addr  (sram_addr[g*ADDR_W +: ADDR_W]),
      .sram_wdata (sram_wdata[g*DATA_W +: DATA_W])
    );
  end

  // The SRAM strobe is issued from PEND itself, so PEND doubles as the access cycle.
  always_ff @(posedge clk or negedge cptra_rst_b) begin
    if (!cptra_rst_b) begin
      mode_q          <= MODE_LOAD;
      core_hold       <= 1'b1;
      hs_q            <= HS_IDLE;
      lat_we          <= 1'b0;
      lat_be          <= '0;
      lat_ch          <= '0;
      lat_addr        <= '0;
      lat_wdata       <= '0;
      hif.host_ack    <= 1'b0;
      hif.host_err    <= 1'b0;
      hif.host_rdata  <= '0;
    end else begin
      if ((mode_q != MODE_LOCKED) && lock) begin
        mode_q    <= MODE_LOCKED;
        core_hold <= 1'b0;
      end else if ((mode_q == MODE_LOAD) && load_go) begin
        mode_q    <= MODE_RUN;
        core_hold <= 1'b0;
      end

      case (hs_q)
        HS_IDLE: begin
          if (hif.host_req) begin
            lat_we    <= hif.host_we;
            lat_be    <= hif.host_be;
            lat_ch    <= hif.host_ch;
            lat_addr  <= hif.host_addr;
            lat_wdata <= hif.host_wdata;
            hs_q      <= HS_PEND;
          end
        end
        HS_PEND: begin
          if (!ch_ok || (mode_q == MODE_LOCKED)) begin
            hs_q           <= HS_ACK;
            hif.host_ack   <= 1'b1;
            hif.host_err   <= 1'b1;
            hif.host_rdata <= '0;
          end else if (|host_grant) begin
            if (lat_we) begin
              hs_q           <= HS_ACK;
              hif.host_ack   <= 1'b1;
              hif.host_err   <= 1'b0;
              hif.host_rdata <= '0;
            end else begin
              hs_q <= HS_RDCAP;
            end
          end
        end
        HS_RDCAP: begin
          hs_q           <= HS_ACK;
          hif.host_ack   <= 1'b1;
          hif.host_err   <= 1'b0;
          hif.host_rdata <= sel_rdata;
        end
        HS_ACK: begin
          hs_q         <= HS_IDLE;
          hif.host_ack <= 1'b0;
          hif.host_err <= 1'b0;
        end
        default: hs_q <= HS_IDLE;
      endcase
    end
  end

`ifdef FPGA_SRAM_LOADER_CKSUM_EN
  logic              host_wr_done;
  logic [DATA_W-1:0] wmask;
  logic [31:0]       wsum;

  assign host_wr_done = (hs_q == HS_PEND) && lat_we && (|host_grant);

  always_comb begin
    wmask = '0;
    for (int unsigned b = 0; b < BE_W; b++) begin
      wmask[b*8 +: 8] = lat_be[b] ? lat_wdata[b*8 +: 8] : 8'h00;
    end
  end

  assign wsum = 32'(wmask);

  always_ff @(posedge clk or negedge cptra_rst_b) begin
    if (!cptra_rst_b) begin
      cksum <= '0;
    end else if (host_wr_done) begin
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        if (lat_ch == CH_W'(c)) begin
          cksum[c*32 +: 32] <= cksum[c*32 +: 32] + wsum;
        end
      end
    end
  end
`else
  assign cksum = '0;
`endif

endmodule
